// File: rtl/gray_decoder.sv
// gray_decoder: synchronizes a gray-coded count, converts it to binary and
// checks that it advances by exactly one, with a saturating illegal-step count.
module gray_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] gray_in,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  valid,
    output logic                  inc,
    output logic                  wrap,
    output logic                  step_err,
    output logic [ERR_WIDTH-1:0]  err_count
);
    localparam int FW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {FILL, ACQUIRE, TRACK} state_t;

    state_t                state_q;
    logic [FW-1:0]         fill_q;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] bin_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  valid_q;
    logic                  inc_q;
    logic                  wrap_q;
    logic                  step_err_q;
    logic [ERR_WIDTH-1:0]  err_count_q;
    logic [DATA_WIDTH-1:0] cur_d;
    logic [DATA_WIDTH-1:0] diff_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // each binary bit is the parity of the gray bits at and above it
    always_comb begin
        cur_d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) cur_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        diff_d = cur_d - prev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            fill_q      <= '0;
            bin_q       <= '0;
            prev_q      <= '0;
            valid_q     <= 1'b0;
            inc_q       <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            inc_q      <= 1'b0;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
            if (en) begin
                bin_q <= cur_d;
                case (state_q)
                    FILL: begin
                        if (fill_q == FW'(SYNC_STAGES)) state_q <= ACQUIRE;
                        else fill_q <= fill_q + 1'b1;
                    end
                    ACQUIRE: begin
                        prev_q  <= cur_d;
                        valid_q <= 1'b1;
                        state_q <= TRACK;
                    end
                    default: begin
                        if (diff_d == DATA_WIDTH'(1)) begin
                            inc_q  <= 1'b1;
                            wrap_q <= (cur_d == '0);
                            prev_q <= cur_d;
                        end else if (diff_d != '0) begin
                            step_err_q  <= 1'b1;
                            err_count_q <= (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
                            prev_q      <= cur_d;
                            state_q     <= ACQUIRE;
                        end
                    end
                endcase
            end
        end
    end

    assign bin_out   = bin_q;
    assign valid     = valid_q;
    assign inc       = inc_q;
    assign wrap      = wrap_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;
endmodule
